// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencing controller: FunSel codes, condition
// codes, ZCNO flag bit positions and the controller state enum.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 8;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned CC_W       = 4;
  localparam int unsigned FLAG_W     = 4;

  localparam logic [OP_W-1:0] ALU_PASS_A = 4'h0;
  localparam logic [OP_W-1:0] ALU_PASS_B = 4'h1;
  localparam logic [OP_W-1:0] ALU_NOT_A  = 4'h2;
  localparam logic [OP_W-1:0] ALU_NOT_B  = 4'h3;
  localparam logic [OP_W-1:0] ALU_ADD    = 4'h4;
  localparam logic [OP_W-1:0] ALU_SUB    = 4'h5;
  localparam logic [OP_W-1:0] ALU_CMP    = 4'h6;
  localparam logic [OP_W-1:0] ALU_AND    = 4'h7;
  localparam logic [OP_W-1:0] ALU_OR     = 4'h8;
  localparam logic [OP_W-1:0] ALU_NAND   = 4'h9;
  localparam logic [OP_W-1:0] ALU_XOR    = 4'hA;
  localparam logic [OP_W-1:0] ALU_LSL    = 4'hB;
  localparam logic [OP_W-1:0] ALU_LSR    = 4'hC;
  localparam logic [OP_W-1:0] ALU_ASL    = 4'hD;
  localparam logic [OP_W-1:0] ALU_ASR    = 4'hE;
  localparam logic [OP_W-1:0] ALU_CSR    = 4'hF;

  localparam logic [CC_W-1:0] CC_AL = 4'd0;
  localparam logic [CC_W-1:0] CC_EQ = 4'd1;
  localparam logic [CC_W-1:0] CC_NE = 4'd2;
  localparam logic [CC_W-1:0] CC_CS = 4'd3;
  localparam logic [CC_W-1:0] CC_CC = 4'd4;
  localparam logic [CC_W-1:0] CC_MI = 4'd5;
  localparam logic [CC_W-1:0] CC_PL = 4'd6;
  localparam logic [CC_W-1:0] CC_VS = 4'd7;
  localparam logic [CC_W-1:0] CC_VC = 4'd8;
  localparam logic [CC_W-1:0] CC_HI = 4'd9;
  localparam logic [CC_W-1:0] CC_LS = 4'd10;
  localparam logic [CC_W-1:0] CC_GE = 4'd11;
  localparam logic [CC_W-1:0] CC_LT = 4'd12;
  localparam logic [CC_W-1:0] CC_GT = 4'd13;
  localparam logic [CC_W-1:0] CC_LE = 4'd14;
  localparam logic [CC_W-1:0] CC_NV = 4'd15;

  localparam int unsigned ZCNO_Z = 3;
  localparam int unsigned ZCNO_C = 2;
  localparam int unsigned ZCNO_N = 1;
  localparam int unsigned ZCNO_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator over ZCNO flags.
module cond_eval
  import alu_pkg::*;
(
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [CC_W-1:0]   cond_i,
  output logic              hit_o
);

  logic z, c, n, o;

  assign z = flags_i[ZCNO_Z];
  assign c = flags_i[ZCNO_C];
  assign n = flags_i[ZCNO_N];
  assign o = flags_i[ZCNO_O];

  always_comb begin
    hit_o = 1'b0;
    case (cond_i)
      CC_AL:   hit_o = 1'b1;
      CC_EQ:   hit_o = z;
      CC_NE:   hit_o = !z;
      CC_CS:   hit_o = c;
      CC_CC:   hit_o = !c;
      CC_MI:   hit_o = n;
      CC_PL:   hit_o = !n;
      CC_VS:   hit_o = o;
      CC_VC:   hit_o = !o;
      CC_HI:   hit_o = c && !z;
      CC_LS:   hit_o = !c || z;
      CC_GE:   hit_o = (n == o);
      CC_LT:   hit_o = (n != o);
      CC_GT:   hit_o = !z && (n == o);
      CC_LE:   hit_o = z || (n != o);
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_controller.sv
// Sequences one ALU operation per request: drive operands, capture the
// registered ALU result and flags, evaluate a condition, return a response.
module alu_controller
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [CC_W-1:0]   req_cond,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_cond,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_funsel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_zcno
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_funsel_q, alu_funsel_d;
  logic [CC_W-1:0]     cond_q, cond_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
  logic                rsp_cond_q, rsp_cond_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                cond_hit;

  // Verdict is evaluated on the live ALU flags so it registers alongside them.
  cond_eval u_cond_eval (
    .flags_i (alu_zcno),
    .cond_i  (cond_q),
    .hit_o   (cond_hit)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Funsel falls back to pass-A whenever no operation is in flight.
  always_comb begin
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_funsel_d = ALU_PASS_A;
    cond_d       = cond_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_cond_d   = rsp_cond_q;
    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    rsp_valid_d  = (state_d == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_a_d      = req_a;
          alu_b_d      = req_b;
          alu_funsel_d = req_op;
          cond_d       = req_cond;
        end
      end
      ST_ISSUE: alu_funsel_d = alu_funsel_q;
      ST_WAIT: begin
        rsp_result_d = alu_out;
        rsp_flags_d  = alu_zcno;
        rsp_cond_d   = cond_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_funsel_q <= ALU_PASS_A;
      cond_q       <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_cond_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_funsel_q <= alu_funsel_d;
      cond_q       <= cond_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_cond_q   <= rsp_cond_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_cond   = rsp_cond_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_funsel = alu_funsel_q;

endmodule

// File: tb/tb_alu_controller.sv
// Bench for alu_controller: an 8-bit ALU model closes the loop, a timeline
// model predicts every output each cycle, and directed vectors pin the values.
module tb_alu_controller;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = 4'h0;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic [3:0] req_cond = 4'h0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       rsp_cond;
  logic       busy;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_funsel;
  logic [7:0] alu_out_m = 8'h00;
  logic [3:0] alu_zcno_m = 4'h0;
  logic [3:0] sw_f = 4'h0, sw_c = 4'h0;
  logic       sw_hit;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_controller #(.DATA_W(8)) dut (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cond(req_cond),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_cond(rsp_cond), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funsel(alu_funsel),
    .alu_out(alu_out_m), .alu_zcno(alu_zcno_m)
  );

  cond_eval u_sweep (.flags_i(sw_f), .cond_i(sw_c), .hit_o(sw_hit));

  // Behaviour of the 8-bit ALU: returns {result, ZCNO}; C/O persist when unaffected.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [3:0] zin);
    logic [8:0] s;
    logic [7:0] r;
    logic c, o;
    c = zin[2];
    o = zin[0];
    r = a;
    case (op)
      4'h0: r = a;
      4'h1: r = b;
      4'h2: r = ~a;
      4'h3: r = ~b;
      4'h4: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        o = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'h5, 4'h6: begin
        r = a - b;
        c = (a < b);
        o = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'h7: r = a & b;
      4'h8: r = a | b;
      4'h9: r = ~(a & b);
      4'hA: r = a ^ b;
      4'hB: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'hC: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'hD: begin r = {a[6:0], 1'b0}; c = a[7]; o = a[7] ^ a[6]; end
      4'hE: begin r = {a[7], a[7:1]}; c = a[0]; end
      default: begin r = {zin[2], a[7:1]}; c = a[0]; end
    endcase
    return {r, (r == 8'h00), c, r[7], o};
  endfunction

  function automatic logic cc_ref(input logic [3:0] f, input logic [3:0] cc);
    logic z, c, n, o;
    logic [15:0] t;
    z = f[3]; c = f[2]; n = f[1]; o = f[0];
    t = {1'b0, z | (n ^ o), ~z & ~(n ^ o), n ^ o, ~(n ^ o), ~c | z, c & ~z,
         ~o, o, ~n, n, ~c, c, ~z, z, 1'b1};
    return t[cc];
  endfunction

  always @(posedge clk) {alu_out_m, alu_zcno_m} <= alu_fn(alu_funsel, alu_a, alu_b, alu_zcno_m);

  // Timeline model: phase counts cycles since acceptance (0 = idle, 3 = response).
  int          phase = 0;
  logic [7:0]  m_a = 0, m_b = 0, m_res = 0;
  logic [3:0]  m_op = 0, m_cc = 0, m_flags = 0;
  logic        m_cond = 0;
  logic [11:0] m_pend = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; m_a = 0; m_b = 0; m_op = 0; m_cc = 0;
      m_res = 0; m_flags = 0; m_cond = 0;
    end else begin
      case (phase)
        0: if (req_valid) begin
          m_a = req_a; m_b = req_b; m_op = req_op; m_cc = req_cond;
          m_pend = alu_fn(req_op, req_a, req_b, alu_zcno_m);
          phase = 1;
        end
        1: phase = 2;
        2: begin
          m_res = m_pend[11:4];
          m_flags = m_pend[3:0];
          m_cond = cc_ref(m_pend[3:0], m_cc);
          phase = 3;
        end
        default: if (rsp_ready) phase = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] cc, output int lat);
    int n;
    req_op = op; req_a = a; req_b = b; req_cond = cc; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!rsp_valid) chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int lat;
    #1 rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(phase == 0));
        chk("busy", 32'(busy), 32'(phase != 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(phase == 3));
        chk("rsp_result", 32'(rsp_result), 32'(m_res));
        chk("rsp_flags", 32'(rsp_flags), 32'(m_flags));
        chk("rsp_cond", 32'(rsp_cond), 32'(m_cond));
        chk("alu_funsel", 32'(alu_funsel), 32'((phase == 1 || phase == 2) ? m_op : 4'h0));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_funsel", 32'(alu_funsel), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    rsp_ready = 1'b1;
    run(ALU_ADD, 8'h7F, 8'h01, CC_VS, lat);
    chk("add_latency", 32'(lat), 32'd3);
    chk("add_result", 32'(rsp_result), 32'h80);
    chk("add_flags", 32'(rsp_flags), 32'b0011);
    chk("add_cond", 32'(rsp_cond), 32'd1);
    @(negedge clk);

    run(ALU_SUB, 8'h05, 8'h05, CC_EQ, lat);
    chk("sub_result", 32'(rsp_result), 32'h00);
    chk("sub_flags", 32'(rsp_flags), 32'b1000);
    chk("sub_eq", 32'(rsp_cond), 32'd1);
    @(negedge clk);
    run(ALU_SUB, 8'h05, 8'h05, CC_NE, lat);
    chk("sub_ne", 32'(rsp_cond), 32'd0);
    chk("b2b_latency", 32'(lat), 32'd3);
    @(negedge clk);

    run(ALU_LSL, 8'h81, 8'h00, CC_CS, lat);
    chk("lsl_result", 32'(rsp_result), 32'h02);
    chk("lsl_flags", 32'(rsp_flags), 32'b0100);
    chk("lsl_cond", 32'(rsp_cond), 32'd1);
    @(negedge clk);
    run(ALU_CSR, 8'h02, 8'h00, CC_AL, lat);
    chk("csr_result", 32'(rsp_result), 32'h81);
    chk("csr_flags", 32'(rsp_flags), 32'b0010);
    @(negedge clk);

    rsp_ready = 1'b0;
    run(ALU_XOR, 8'hF0, 8'h0F, CC_MI, lat);
    req_op = ALU_ADD; req_a = 8'h55; req_b = 8'h11; req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_result", 32'(rsp_result), 32'hFF);
      chk("bp_cond", 32'(rsp_cond), 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);

    req_op = ALU_ADD; req_a = 8'h11; req_b = 8'h22; req_cond = CC_AL; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_funsel", 32'(alu_funsel), 32'(ALU_ADD));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_funsel", 32'(alu_funsel), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run(ALU_ADD, 8'h10, 8'h20, CC_PL, lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_result", 32'(rsp_result), 32'h30);
    chk("post_rst_flags", 32'(rsp_flags), 32'b0000);
    chk("post_rst_cond", 32'(rsp_cond), 32'd1);
    @(negedge clk);

    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        sw_f = 4'(f);
        sw_c = 4'(c);
        #1;
        chk("cond_sweep", 32'(sw_hit), 32'(cc_ref(sw_f, sw_c)));
        if (c == 0) chk("cond_al", 32'(sw_hit), 32'd1);
        if (c == 15) chk("cond_nv", 32'(sw_hit), 32'd0);
      end
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
